// File: rtl/cpu_pkg.sv
// Shared CPU types for the write-back path.
// Register-index width, zero register, and the queued result entry.
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] addr;
    logic [31:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/cpu_wb_fifo.sv
// Circular buffer of MDU results with per-entry live bits,
// an address squash port and two CAM-style lookup ports.
module cpu_wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  input  logic              kill,
  input  logic [REG_AW-1:0] kill_addr,
  input  logic [REG_AW-1:0] look1,
  input  logic [REG_AW-1:0] look2,
  output logic              hit1,
  output logic              hit2,
  output wb_entry_t         head,
  output logic [CW-1:0]     count
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd;
  logic [PW-1:0]   wr;

  // Live is cleared on pop, so a set live bit always marks an occupied slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].live <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && mem[i].addr == kill_addr) begin
          mem[i].live <= 1'b0;
        end
      end
      if (pop) begin
        mem[rd].live <= 1'b0;
        rd <= rd + PW'(1);
      end
      if (push) begin
        mem[wr] <= push_entry;
        wr <= wr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].live && mem[i].addr == look1) hit1 = 1'b1;
      if (mem[i].live && mem[i].addr == look2) hit2 = 1'b1;
    end
  end

  assign head = mem[rd];

endmodule

// File: rtl/cpu_wb_arbiter.sv
// Regfile write-port arbiter: ALU write-back always wins,
// buffered MDU results drain into idle write-port cycles.
module cpu_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_waddr,
  input  logic [31:0]   alu_wdata,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [AW-1:0] mdu_waddr,
  input  logic [31:0]   mdu_wdata,
  output logic          we,
  output logic [31:0]   waddr,
  output logic [31:0]   wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic          pend1,
  output logic          pend2,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic              hit1;
  logic              hit2;
  logic              alu_wr;
  logic              xfer;
  logic              push;
  logic              pop;
  logic              kill;
  logic [REG_AW-1:0] alu_a;
  logic [REG_AW-1:0] mdu_a;

  assign alu_a = REG_AW'(alu_waddr);
  assign mdu_a = REG_AW'(mdu_waddr);

  assign mdu_ready = count != FULL;
  assign xfer      = mdu_valid && mdu_ready;
  assign alu_wr    = alu_valid && alu_a != REG_ZERO;

  // A same-cycle MDU result to the ALU's target is older, so it is dropped.
  assign push = !rst && xfer && mdu_a != REG_ZERO
             && !(alu_wr && mdu_a == alu_a);
  assign pop  = !rst && !alu_valid && count != '0;
  assign kill = !rst && alu_wr;

  assign push_entry = '{live: 1'b1, addr: mdu_a, data: mdu_wdata};

  cpu_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .kill      (kill),
    .kill_addr (alu_a),
    .look1     (REG_AW'(raddr1)),
    .look2     (REG_AW'(raddr2)),
    .hit1      (hit1),
    .hit2      (hit2),
    .head      (head),
    .count     (count)
  );

  // The write port is held idle during reset so queued results never commit.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!rst) begin
      if (alu_wr) begin
        we    = 1'b1;
        waddr = 32'(alu_waddr);
        wdata = alu_wdata;
      end else if (pop) begin
        we    = head.live;
        waddr = 32'(head.addr);
        wdata = head.data;
      end
    end
  end

  assign pend1 = hit1 && raddr1 != '0;
  assign pend2 = hit2 && raddr2 != '0;

endmodule
